// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one shared AND/OR/XOR/NOR unit with a tagged result register.
// Latency: an op accepted at edge k is presented on rsp_* right after edge k; full rate while rsp_ready=1.
// Backpressure: while the result register is full and rsp_ready=0, both req ready outputs drop and rsp_* hold.
module logic_unit_arbiter #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [1:0]           req0_op,
   input  logic [WIDTH-1:0]     req0_operandA,
   input  logic [WIDTH-1:0]     req0_operandB,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [1:0]           req1_op,
   input  logic [WIDTH-1:0]     req1_operandA,
   input  logic [WIDTH-1:0]     req1_operandB,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [WIDTH-1:0]     rsp_result,
   output logic                 rsp_zero,
   output logic [CNT_WIDTH-1:0] grant_count0,
   output logic [CNT_WIDTH-1:0] grant_count1
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic             last_grant;
   logic             slot_free;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             accept_id;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] next_result;

   function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a | b);
      endcase
      return r;
   endfunction

   // Arbitration: a lone valid wins; on a tie the port that did not win last time goes.
   always_comb begin
      slot_free  = (state == EMPTY) | rsp_ready;
      grant0     = req0_valid & (~req1_valid | last_grant);
      grant1     = req1_valid & (~req0_valid | ~last_grant);
      req0_ready = slot_free & grant0;
      req1_ready = slot_free & grant1;
      accept     = req0_ready | req1_ready;
      accept_id  = req1_ready;
   end

   // Operand steering to the single shared logic unit.
   always_comb begin
      sel_op      = accept_id ? req1_op       : req0_op;
      sel_a       = accept_id ? req1_operandA : req0_operandA;
      sel_b       = accept_id ? req1_operandB : req0_operandB;
      next_result = logic_fn(sel_op, sel_a, sel_b);
   end

   assign rsp_valid = (state == FULL);

   // Result register FSM, round-robin pointer and saturating grant counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= EMPTY;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b1;
         last_grant   <= 1'b1;
         grant_count0 <= '0;
         grant_count1 <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) state <= FULL;
            FULL:  if (rsp_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         if (accept) begin
            rsp_result <= next_result;
            rsp_id     <= accept_id;
            rsp_zero   <= (next_result == '0);
            last_grant <= accept_id;
         end
         if (req0_ready && grant_count0 != '1) grant_count0 <= grant_count0 + CNT_ONE;
         if (req1_ready && grant_count1 != '1) grant_count1 <= grant_count1 + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: scoreboard of expected responses plus a small arbitration model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, away from the rising edge.
// A second instance with 2-bit counters shares all inputs to exercise counter saturation.
module tb_logic_unit_arbiter;

   logic        clock;
   logic        reset;
   logic        req0_valid, req1_valid, rsp_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;

   logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero;
   logic [31:0] rsp_result;
   logic [15:0] grant_count0, grant_count1;

   logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_zero;
   logic [31:0] s_rsp_result;
   logic [1:0]  s_grant_count0, s_grant_count1;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t        sb[$];
   bit          exp_full;
   bit          exp_last;
   int          cnt0, cnt1, sat0, sat1;
   int          errors = 0;
   int          checks = 0;

   logic_unit_arbiter #(.WIDTH(32), .CNT_WIDTH(16)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .grant_count0(grant_count0), .grant_count1(grant_count1)
   );

   logic_unit_arbiter #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
      .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
      .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
      .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero),
      .grant_count0(s_grant_count0), .grant_count1(s_grant_count1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic model_reset();
      sb.delete();
      exp_full = 0;
      exp_last = 1;
      cnt0 = 0; cnt1 = 0; sat0 = 0; sat1 = 0;
   endtask

   // Called on a falling edge: drive, sample, compare, advance the model, move to the next falling edge.
   task automatic step(input logic v0, input logic [1:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
      bit   sf, g0, g1;
      exp_t e;
      req0_valid = v0; req0_op = o0; req0_operandA = a0; req0_operandB = b0;
      req1_valid = v1; req1_op = o1; req1_operandA = a1; req1_operandB = b1;
      rsp_ready  = rr;
      #1;
      sf = !exp_full || rr;
      g0 = v0 && (!v1 || exp_last);
      g1 = v1 && (!v0 || !exp_last);
      check("req0_ready", 64'(req0_ready), 64'(sf && g0));
      check("req1_ready", 64'(req1_ready), 64'(sf && g1));
      check("sat_req0_ready", 64'(s_req0_ready), 64'(sf && g0));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_full));
      check("grant_count0", 64'(grant_count0), 64'(cnt0));
      check("grant_count1", 64'(grant_count1), 64'(cnt1));
      check("sat_count0", 64'(s_grant_count0), 64'(sat0));
      check("sat_count1", 64'(s_grant_count1), 64'(sat1));
      if (exp_full) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 64'(0), 64'(1));
         end else begin
            check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
            check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
            check("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
            if (rr) void'(sb.pop_front());
         end
      end
      if (sf && (g0 || g1)) begin
         e.id   = g1;
         e.res  = g1 ? ref_fn(o1, a1, b1) : ref_fn(o0, a0, b0);
         e.zero = (e.res == 32'h0);
         sb.push_back(e);
         exp_last = g1;
         if (g0) begin
            if (cnt0 < 65535) cnt0++;
            if (sat0 < 3) sat0++;
         end else begin
            if (cnt1 < 65535) cnt1++;
            if (sat1 < 3) sat1++;
         end
      end
      exp_full = (sf && (g0 || g1)) || (exp_full && !rr);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, rr);
   endtask

   initial begin
      model_reset();
      reset = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_op = 0; req1_op = 0;
      req0_operandA = 0; req0_operandB = 0; req1_operandA = 0; req1_operandB = 0;
      @(negedge clock);
      #1;
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_rsp_id", 64'(rsp_id), 64'(0));
      check("reset_rsp_result", 64'(rsp_result), 64'(0));
      check("reset_rsp_zero", 64'(rsp_zero), 64'(1));
      check("reset_count0", 64'(grant_count0), 64'(0));
      check("reset_count1", 64'(grant_count1), 64'(0));
      @(negedge clock);
      reset = 1'b1;

      // Single OR op from port 0.
      step(1, 2'b01, 32'h0000_00F0, 32'h0000_000F, 0, 2'b00, 32'h0, 32'h0, 1);
      #1;
      check("single_valid", 64'(rsp_valid), 64'(1));
      check("single_result", 64'(rsp_result), 64'h0000_00FF);
      check("single_id", 64'(rsp_id), 64'(0));
      check("single_zero", 64'(rsp_zero), 64'(0));
      #0;

      // Hold the result, then reset in the middle of the cycle.
      step(0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("async_rsp_valid", 64'(rsp_valid), 64'(0));
      check("async_count0", 64'(grant_count0), 64'(0));
      check("async_sat_count0", 64'(s_grant_count0), 64'(0));
      model_reset();
      @(negedge clock);
      reset = 1'b1;

      // Round robin with both ports valid: expect 0,1,0,1.
      for (int i = 0; i < 4; i++) begin
         check("rr_grant0", 64'(1), 64'(1));
         step(1, 2'b00, 32'hFFFF_0000 + 32'(i), 32'h0F0F_0F0F, 1, 2'b10, 32'h1234_5678, 32'(i), 1);
         #1;
         check("rr_id", 64'(rsp_id), 64'(i % 2));
      end
      check("rr_count0", 64'(grant_count0), 64'(2));
      check("rr_count1", 64'(grant_count1), 64'(2));

      // Stall with a full register, then release.
      for (int i = 0; i < 3; i++)
         step(1, 2'b01, 32'hA5A5_0000, 32'h0000_5A5A, 1, 2'b11, 32'h0F00_0000, 32'h00F0_0000, 0);
      step(1, 2'b01, 32'hA5A5_0000, 32'h0000_5A5A, 1, 2'b11, 32'h0F00_0000, 32'h00F0_0000, 1);
      idle(1);

      // Zero flag cases on port 1.
      step(0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
      #1;
      check("xor_result", 64'(rsp_result), 64'(0));
      check("xor_zero", 64'(rsp_zero), 64'(1));
      check("xor_id", 64'(rsp_id), 64'(1));
      step(0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      #1;
      check("nor_result", 64'(rsp_result), 64'(0));
      check("nor_zero", 64'(rsp_zero), 64'(1));

      // Saturation of the 2-bit counter on port 0.
      for (int i = 0; i < 5; i++)
         step(1, 2'b00, 32'hFFFF_FFFF, 32'(i + 1), 0, 2'b00, 32'h0, 32'h0, 1);
      #1;
      check("sat_stays_max", 64'(s_grant_count0), 64'(2'b11));

      // Random traffic with random backpressure.
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              1'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) idle(1);
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
